// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-write store buffer.
// Optional exact-match forwarding is enabled with STORE_BUF_FWD_EN.
package store_buffer_pkg;

  localparam int SB_DATA_W = 32;
  localparam int SB_ADDR_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  // Word ranges [a,a+3] and [b,b+3] intersect; widened so a+3 never wraps.
  function automatic logic sb_overlap(
    input logic [SB_ADDR_W-1:0] a,
    input logic [SB_ADDR_W-1:0] b
  );
    logic [SB_ADDR_W:0] ae;
    logic [SB_ADDR_W:0] be;
    ae = {1'b0, a};
    be = {1'b0, b};
    return (ae <= be + (SB_ADDR_W+1)'(3)) &&
           (be <= ae + (SB_ADDR_W+1)'(3));
  endfunction

endpackage

// File: rtl/sb_match_unit.sv
// Per-entry load overlap compare; with STORE_BUF_FWD_EN also the
// exact-match vector and youngest overlapping entry (offset from head).
module sb_match_unit
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]     vld,
  input  logic [SB_ADDR_W-1:0] addrs [DEPTH],
  input  logic [SB_ADDR_W-1:0] ld_addr,
  output logic [DEPTH-1:0]     overlap
`ifdef STORE_BUF_FWD_EN
  ,
  input  logic [PTR_W-1:0]     head,
  output logic [DEPTH-1:0]     match,
  output logic [PTR_W-1:0]     yng_off,
  output logic                 yng_hit
`endif
);

  always_comb begin
    overlap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      overlap[i] = vld[i] && sb_overlap(addrs[i], ld_addr);
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [PTR_W-1:0] idx;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = vld[i] && (addrs[i] == ld_addr);
    end
  end

  // Walk oldest to youngest; the last overlapping entry wins.
  always_comb begin
    yng_off = '0;
    yng_hit = 1'b0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (overlap[idx]) begin
        yng_off = PTR_W'(k);
        yng_hit = match[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/store_buffer.sv
// Posted-write store FIFO in front of the 32-byte big-endian data memory.
// Define STORE_BUF_FWD_EN to forward exact-match stores to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid,
  input  logic [SB_ADDR_W-1:0] st_addr,
  input  logic [SB_DATA_W-1:0] st_data,
  output logic                 st_ready,
  input  logic                 ld_valid,
  input  logic [SB_ADDR_W-1:0] ld_addr,
  output logic [SB_DATA_W-1:0] ld_data,
  output logic                 ld_ready,
  output logic [SB_ADDR_W-1:0] dm_addr,
  output logic [SB_DATA_W-1:0] dm_wdata,
  output logic                 dm_write,
  input  logic [SB_DATA_W-1:0] dm_rdata,
  output logic                 sb_empty,
  output logic [PTR_W:0]       sb_count
);

  sb_entry_t            entries [DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W:0]       count;
  logic [DEPTH-1:0]     vld;
  logic [SB_ADDR_W-1:0] addrs [DEPTH];
  logic [DEPTH-1:0]     overlap;
  logic                 any_ovl;
  logic                 load_own;
  logic                 push;
  logic                 pop;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld[i]   = entries[i].valid;
      addrs[i] = entries[i].addr;
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] yng_off;
  logic             yng_hit;
  logic [PTR_W-1:0] fwd_idx;
  assign fwd_idx = head + yng_off;
`endif

  sb_match_unit #(.DEPTH(DEPTH)) u_match (
    .vld     (vld),
    .addrs   (addrs),
    .ld_addr (ld_addr),
    .overlap (overlap)
`ifdef STORE_BUF_FWD_EN
    ,
    .head    (head),
    .match   (match),
    .yng_off (yng_off),
    .yng_hit (yng_hit)
`endif
  );

  assign any_ovl  = |overlap;
  assign load_own = ld_valid && !any_ovl;
  assign st_ready = count < (PTR_W+1)'(DEPTH);
  assign push     = st_valid && st_ready;
  assign pop      = (count != '0) && !load_own;
  assign sb_empty = (count == '0);
  assign sb_count = count;

  always_comb begin
    dm_addr  = '0;
    dm_wdata = '0;
    dm_write = 1'b0;
    ld_ready = 1'b0;
    ld_data  = '0;
    if (load_own) begin
      dm_addr  = ld_addr;
      ld_data  = dm_rdata;
      ld_ready = 1'b1;
    end else if (count != '0) begin
      dm_addr  = entries[head].addr;
      dm_wdata = entries[head].data;
      dm_write = 1'b1;
    end
`ifdef STORE_BUF_FWD_EN
    if (ld_valid && any_ovl && yng_hit) begin
      ld_ready = 1'b1;
      ld_data  = entries[fwd_idx].data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (push) begin
        entries[tail] <= '{valid: 1'b1, addr: st_addr, data: st_data};
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a 32-byte big-endian DM model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_write;
  logic [31:0] dm_rdata;
  logic        sb_empty;
  logic [2:0]  sb_count;

  logic [7:0]  mem [32];
  logic        dm_clear;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_write (dm_write),
    .dm_rdata (dm_rdata),
    .sb_empty (sb_empty),
    .sb_count (sb_count)
  );

  // DM: writes on negedge, combinational big-endian read.
  always @(negedge clk) begin
    if (dm_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h80 | 8'(i);
    end else if (dm_write) begin
      for (int k = 0; k < 4; k++)
        mem[5'(dm_addr[4:0] + 5'(k))] <= dm_wdata[31-8*k -: 8];
    end
  end

  always_comb begin
    dm_rdata = '0;
    for (int k = 0; k < 4; k++)
      dm_rdata[31-8*k -: 8] = mem[5'(dm_addr[4:0] + 5'(k))];
  end

  function automatic logic [31:0] memword(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL rst_st_ready got %b want 1", st_ready); end
    n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b want 1", sb_empty); end
    n_cmp++; if (sb_count !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", sb_count); end
    n_cmp++; if (dm_write !== 1'b0) begin n_bad++; $display("FAIL rst_dm_write got %b want 0", dm_write); end
    n_cmp++; if (dm_addr !== 32'h0) begin n_bad++; $display("FAIL rst_dm_addr got %h want 0", dm_addr); end
    n_cmp++; if (dm_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_dm_wdata got %h want 0", dm_wdata); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ld_ready got %b want 0", ld_ready); end
  endtask

  task automatic test_drain();
    cyc();
    st_valid = 1; st_addr = 32'h00; st_data = 32'h11223344; #1;
    n_cmp++; if (dm_write !== 1'b0) begin n_bad++; $display("FAIL drain_idle got %b want 0", dm_write); end
    cyc();
    st_addr = 32'h04; st_data = 32'h55667788; #1;
    n_cmp++; if (dm_write !== 1'b1 || dm_addr !== 32'h00 || dm_wdata !== 32'h11223344) begin
      n_bad++; $display("FAIL drain_w0 got %b %h %h want 1 0 11223344", dm_write, dm_addr, dm_wdata); end
    cyc();
    st_addr = 32'h08; st_data = 32'hAABBCCDD; #1;
    n_cmp++; if (dm_write !== 1'b1 || dm_addr !== 32'h04 || dm_wdata !== 32'h55667788) begin
      n_bad++; $display("FAIL drain_w1 got %b %h %h want 1 4 55667788", dm_write, dm_addr, dm_wdata); end
    n_cmp++; if (sb_count !== 3'd1) begin n_bad++; $display("FAIL drain_pushpop got %0d want 1", sb_count); end
    cyc();
    st_valid = 0; #1;
    n_cmp++; if (dm_write !== 1'b1 || dm_addr !== 32'h08 || dm_wdata !== 32'hAABBCCDD) begin
      n_bad++; $display("FAIL drain_w2 got %b %h %h want 1 8 aabbccdd", dm_write, dm_addr, dm_wdata); end
    cyc();
    n_cmp++; if (sb_empty !== 1'b1 || dm_write !== 1'b0 || dm_addr !== 32'h0) begin
      n_bad++; $display("FAIL drain_done got %b %b %h want 1 0 0", sb_empty, dm_write, dm_addr); end
    n_cmp++; if (memword(0) !== 32'h11223344) begin n_bad++; $display("FAIL drain_mem0 got %h want 11223344", memword(0)); end
    n_cmp++; if (memword(4) !== 32'h55667788) begin n_bad++; $display("FAIL drain_mem4 got %h want 55667788", memword(4)); end
    n_cmp++; if (memword(8) !== 32'hAABBCCDD) begin n_bad++; $display("FAIL drain_mem8 got %h want aabbccdd", memword(8)); end
  endtask

  task automatic test_fill();
    cyc();
    ld_valid = 1; ld_addr = 32'h1C; st_valid = 1;
    for (int i = 0; i < 4; i++) begin
      st_addr = 32'(4 * i);
      st_data = 32'hA0A1A2A3 + 32'(i) * 32'h10101010;
      #1;
      n_cmp++; if (dm_write !== 1'b0 || ld_ready !== 1'b1 || ld_data !== 32'h9C9D9E9F) begin
        n_bad++; $display("FAIL fill_load%0d got %b %b %h want 0 1 9c9d9e9f", i, dm_write, ld_ready, ld_data); end
      cyc();
    end
    st_addr = 32'h10; st_data = 32'hFFFFFFFF; #1;
    n_cmp++; if (st_ready !== 1'b0 || sb_count !== 3'd4 || dm_write !== 1'b0) begin
      n_bad++; $display("FAIL fill_full got %b %0d %b want 0 4 0", st_ready, sb_count, dm_write); end
    cyc();
    n_cmp++; if (sb_count !== 3'd4) begin n_bad++; $display("FAIL fill_nopush got %0d want 4", sb_count); end
    ld_valid = 0; st_valid = 0; #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (dm_write !== 1'b1 || dm_addr !== 32'(4 * i)) begin
        n_bad++; $display("FAIL fill_drain%0d got %b %h want 1 %h", i, dm_write, dm_addr, 4 * i); end
      cyc();
    end
    n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL fill_empty got %b want 1", sb_empty); end
    n_cmp++; if (memword(12) !== 32'hD0D1D2D3) begin n_bad++; $display("FAIL fill_mem12 got %h want d0d1d2d3", memword(12)); end
    n_cmp++; if (memword(28) !== 32'h9C9D9E9F) begin n_bad++; $display("FAIL fill_mem28 got %h want 9c9d9e9f", memword(28)); end
  endtask

  task automatic test_fwd();
    cyc();
    st_valid = 1; st_addr = 32'h10; st_data = 32'hDEADBEEF;
    cyc();
    st_valid = 0; ld_valid = 1; ld_addr = 32'h10; #1;
    n_cmp++; if (dm_write !== 1'b1) begin n_bad++; $display("FAIL fwd_drain got %b want 1", dm_write); end
`ifdef STORE_BUF_FWD_EN
    n_cmp++; if (ld_ready !== 1'b1 || ld_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL fwd_hit got %b %h want 1 deadbeef", ld_ready, ld_data); end
`else
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL fwd_stall got %b want 0", ld_ready); end
`endif
    cyc();
    n_cmp++; if (ld_ready !== 1'b1 || ld_data !== 32'hDEADBEEF || dm_write !== 1'b0) begin
      n_bad++; $display("FAIL fwd_dm got %b %h %b want 1 deadbeef 0", ld_ready, ld_data, dm_write); end
    ld_valid = 0;
  endtask

  task automatic test_partial();
    cyc();
    st_valid = 1; st_addr = 32'h10; st_data = 32'h01020304;
    cyc();
    st_valid = 0; ld_valid = 1; ld_addr = 32'h12; #1;
    n_cmp++; if (ld_ready !== 1'b0 || dm_write !== 1'b1) begin
      n_bad++; $display("FAIL part_stall got %b %b want 0 1", ld_ready, dm_write); end
    cyc();
    n_cmp++; if (ld_ready !== 1'b1 || ld_data !== 32'h03049495) begin
      n_bad++; $display("FAIL part_data got %b %h want 1 03049495", ld_ready, ld_data); end
    ld_valid = 0;
  endtask

  task automatic test_youngest();
    cyc();
    ld_valid = 1; ld_addr = 32'h1C;
    st_valid = 1; st_addr = 32'h08; st_data = 32'hAAAAAAAA;
    cyc();
    st_data = 32'hBBBBBBBB; #1;
    n_cmp++; if (dm_write !== 1'b0) begin n_bad++; $display("FAIL yng_hold got %b want 0", dm_write); end
    cyc();
    st_valid = 0; ld_addr = 32'h08; #1;
    n_cmp++; if (sb_count !== 3'd2 || dm_write !== 1'b1 || dm_wdata !== 32'hAAAAAAAA) begin
      n_bad++; $display("FAIL yng_drain got %0d %b %h want 2 1 aaaaaaaa", sb_count, dm_write, dm_wdata); end
`ifdef STORE_BUF_FWD_EN
    n_cmp++; if (ld_ready !== 1'b1 || ld_data !== 32'hBBBBBBBB) begin
      n_bad++; $display("FAIL yng_fwd2 got %b %h want 1 bbbbbbbb", ld_ready, ld_data); end
`else
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL yng_stall2 got %b want 0", ld_ready); end
`endif
    cyc();
    n_cmp++; if (sb_count !== 3'd1 || dm_wdata !== 32'hBBBBBBBB) begin
      n_bad++; $display("FAIL yng_second got %0d %h want 1 bbbbbbbb", sb_count, dm_wdata); end
`ifdef STORE_BUF_FWD_EN
    n_cmp++; if (ld_ready !== 1'b1 || ld_data !== 32'hBBBBBBBB) begin
      n_bad++; $display("FAIL yng_fwd1 got %b %h want 1 bbbbbbbb", ld_ready, ld_data); end
`else
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL yng_stall1 got %b want 0", ld_ready); end
`endif
    cyc();
    n_cmp++; if (ld_ready !== 1'b1 || ld_data !== 32'hBBBBBBBB || dm_write !== 1'b0) begin
      n_bad++; $display("FAIL yng_dm got %b %h %b want 1 bbbbbbbb 0", ld_ready, ld_data, dm_write); end
    ld_valid = 0;
  endtask

  task automatic test_reset_mid();
    cyc();
    ld_valid = 1; ld_addr = 32'h00; st_valid = 1;
    st_addr = 32'h14; st_data = 32'hE1E2E3E4;
    cyc();
    st_addr = 32'h18; st_data = 32'hF1F2F3F4;
    cyc();
    st_addr = 32'h1C; st_data = 32'hC1C2C3C4;
    cyc();
    st_valid = 0; ld_valid = 0; #1;
    n_cmp++; if (sb_count !== 3'd3 || dm_write !== 1'b1 || dm_addr !== 32'h14) begin
      n_bad++; $display("FAIL rmid_pre got %0d %b %h want 3 1 14", sb_count, dm_write, dm_addr); end
    rst = 1; #1;
    n_cmp++; if (dm_write !== 1'b0 || sb_count !== 3'd0) begin
      n_bad++; $display("FAIL rmid_drop got %b %0d want 0 0", dm_write, sb_count); end
    n_cmp++; if (st_ready !== 1'b1 || sb_empty !== 1'b1 || dm_addr !== 32'h0) begin
      n_bad++; $display("FAIL rmid_state got %b %b %h want 1 1 0", st_ready, sb_empty, dm_addr); end
    repeat (2) cyc();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (dm_write !== 1'b0) begin n_bad++; $display("FAIL rmid_quiet%0d got %b want 0", i, dm_write); end
    end
    n_cmp++; if (memword(20) !== 32'h94959697) begin n_bad++; $display("FAIL rmid_mem20 got %h want 94959697", memword(20)); end
    n_cmp++; if (memword(24) !== 32'h98999A9B) begin n_bad++; $display("FAIL rmid_mem24 got %h want 98999a9b", memword(24)); end
    n_cmp++; if (memword(28) !== 32'h9C9D9E9F) begin n_bad++; $display("FAIL rmid_mem28 got %h want 9c9d9e9f", memword(28)); end
  endtask

  initial begin
    rst = 1; dm_clear = 1;
    st_valid = 0; st_addr = '0; st_data = '0;
    ld_valid = 0; ld_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 0; dm_clear = 0;
    test_drain();
    test_fill();
    test_fwd();
    test_partial();
    test_youngest();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
